// File: rtl/vproc_result_pkg.sv
// Shared XIF result record, record width helper and id-FIFO sizing for vproc_result_arb.
package vproc_result_pkg;

  localparam int unsigned XIF_ID_W  = 3;
  localparam int unsigned XIF_RFW_W = 32;

  // Field order follows the XIF result interface, id in the most significant bits.
  typedef struct packed {
    logic [XIF_ID_W-1:0]  id;
    logic [XIF_RFW_W-1:0] data;
    logic [4:0]           rd;
    logic                 we;
    logic                 exc;
    logic [5:0]           exccode;
    logic                 err;
    logic                 dbg;
  } result_t;

  function automatic int unsigned result_w(input int unsigned id_w, input int unsigned rfw_w);
    return id_w + rfw_w + 5 + 1 + 1 + 6 + 1 + 1;
  endfunction

  localparam int unsigned RESULT_W = $bits(result_t);

  function automatic int unsigned fifo_depth(input int unsigned id_w);
    return 32'd1 << id_w;
  endfunction

endpackage

// File: rtl/vproc_id_fifo.sv
// Committed-instruction id FIFO (depth 2**ID_W) used to enforce in-order result delivery.
module vproc_id_fifo
  import vproc_result_pkg::*;
#(
  parameter int unsigned ID_W = 3
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic [ID_W-1:0] push_id_i,
  input  logic            pop_i,
  output logic [ID_W-1:0] head_o,
  output logic            full_o,
  output logic            empty_o,
  output logic            err_o
);

  localparam int unsigned DEPTH = fifo_depth(ID_W);

  logic [ID_W-1:0] mem_q [DEPTH];
  logic [ID_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [ID_W:0]   cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign full_o  = (cnt_q == (ID_W+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];

  // A pop frees the head slot, so a push into a full FIFO is legal in the same cycle.
  always_comb begin
    do_pop  = pop_i & ~empty_o;
    do_push = push_i & (~full_o | do_pop);
    err_o   = (push_i & full_o & ~do_pop) | (pop_i & empty_o);
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (do_push) wr_d = wr_q + {{(ID_W-1){1'b0}}, 1'b1};
    if (do_pop)  rd_d = rd_q + {{(ID_W-1){1'b0}}, 1'b1};
    if (do_push && !do_pop)      cnt_d = cnt_q + {{ID_W{1'b0}}, 1'b1};
    else if (do_pop && !do_push) cnt_d = cnt_q - {{ID_W{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= push_id_i;
  end

endmodule

// File: rtl/vproc_result_arb.sv
// Round-robin arbiter of internal result requesters onto the XIF result port, one register stage.
// Optional in-order delivery against committed ids is enabled with `define VPROC_RESULT_INORDER_EN.
module vproc_result_arb
  import vproc_result_pkg::*;
#(
  parameter  int unsigned N_REQ       = 4,
  parameter  int unsigned X_ID_WIDTH  = 3,
  parameter  int unsigned X_RFW_WIDTH = 32,
  localparam int unsigned RES_W       = result_w(X_ID_WIDTH, X_RFW_WIDTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [N_REQ-1:0]       req_valid_i,
  output logic [N_REQ-1:0]       req_ready_o,
  input  logic [N_REQ*RES_W-1:0] req_result_i,
  output logic                   result_valid_o,
  input  logic                   result_ready_i,
  output logic [RES_W-1:0]       result_o,
  input  logic                   commit_valid_i,
  input  logic                   commit_kill_i,
  input  logic [X_ID_WIDTH-1:0]  commit_id_i,
  output logic                   ord_err_o
);

  localparam int unsigned RR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic                  valid_q, valid_d;
  logic [RES_W-1:0]      res_q, res_d;
  logic [RR_W-1:0]       rr_q, rr_d;
  logic                  stage_free, found, grant;
  logic [RR_W-1:0]       win, idx;
  logic [N_REQ-1:0]      elig, gnt_oh;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_err;
  logic [X_ID_WIDTH-1:0] fifo_head;
  logic                  unused_trk;

  function automatic logic [RR_W-1:0] rr_step(input logic [RR_W-1:0] base, input int unsigned ofs);
    int unsigned s;
    s = 32'(base) + ofs;
    if (s >= N_REQ) s = s - N_REQ;
    return RR_W'(s);
  endfunction

  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
`ifdef VPROC_RESULT_INORDER_EN
      elig[i] = req_valid_i[i] & ~fifo_empty &
                (req_result_i[i*RES_W + RES_W - X_ID_WIDTH +: X_ID_WIDTH] == fifo_head);
`else
      elig[i] = req_valid_i[i];
`endif
    end
  end

  // First eligible requester at or after rr_q, wrapping; reset blocks any grant.
  always_comb begin
    stage_free = ~valid_q | result_ready_i;
    found      = 1'b0;
    win        = '0;
    idx        = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = rr_step(rr_q, k);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    grant  = found & stage_free & rst_ni;
    gnt_oh = '0;
    if (grant) gnt_oh[win] = 1'b1;
  end

  always_comb begin
    valid_d = valid_q;
    res_d   = res_q;
    rr_d    = rr_q;
    if (grant) begin
      valid_d = 1'b1;
      res_d   = req_result_i[32'(win)*RES_W +: RES_W];
      rr_d    = rr_step(win, 1);
    end else if (result_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      res_q   <= '0;
      rr_q    <= '0;
    end else begin
      valid_q <= valid_d;
      res_q   <= res_d;
      rr_q    <= rr_d;
    end
  end

  assign req_ready_o    = gnt_oh;
  assign result_valid_o = valid_q;
  assign result_o       = res_q;

`ifdef VPROC_RESULT_INORDER_EN
  logic err_q, err_d;

  assign fifo_push = commit_valid_i & ~commit_kill_i;
  assign fifo_pop  = grant;
  assign err_d     = err_q | fifo_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign ord_err_o  = err_q;
  assign unused_trk = fifo_full;
`else
  assign fifo_push  = 1'b0;
  assign fifo_pop   = 1'b0;
  assign ord_err_o  = 1'b0;
  assign unused_trk = ^{commit_valid_i, commit_kill_i, commit_id_i, fifo_head,
                        fifo_full, fifo_empty, fifo_err};
`endif

  vproc_id_fifo #(
    .ID_W(X_ID_WIDTH)
  ) u_id_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push_i   (fifo_push),
    .push_id_i(commit_id_i),
    .pop_i    (fifo_pop),
    .head_o   (fifo_head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .err_o    (fifo_err)
  );

endmodule

// File: tb/tb_vproc_result_arb.sv
// Self-checking bench for vproc_result_arb: vector table, corner sequences, randomized model run.
module tb_vproc_result_arb;
  import vproc_result_pkg::*;

  localparam int unsigned N   = 4;
  localparam int unsigned IDW = XIF_ID_W;
  localparam int unsigned RW  = RESULT_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid, req_ready;
  logic [N*RW-1:0]   req_result;
  logic              result_valid, result_ready;
  logic [RW-1:0]     result;
  logic              commit_valid, commit_kill;
  logic [IDW-1:0]    commit_id;
  logic              ord_err;

  result_t recs [N];

  int errors = 0;
  int checks = 0;

  vproc_result_arb #(
    .N_REQ      (N),
    .X_ID_WIDTH (IDW),
    .X_RFW_WIDTH(XIF_RFW_W)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_result_i  (req_result),
    .result_valid_o(result_valid),
    .result_ready_i(result_ready),
    .result_o      (result),
    .commit_valid_i(commit_valid),
    .commit_kill_i (commit_kill),
    .commit_id_i   (commit_id),
    .ord_err_o     (ord_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_result = '0;
    for (int i = 0; i < N; i++) req_result[i*RW +: RW] = recs[i];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: output slot, next-preferred requester, queue of committed ids.
  bit      m_valid;
  result_t m_out;
  int      m_rr;
  int      m_q[$];
  bit      m_err;

  task automatic model_reset();
    m_valid = 1'b0;
    m_out   = '0;
    m_rr    = 0;
    m_q.delete();
    m_err   = 1'b0;
  endtask

  function automatic int m_pick();
    if (m_valid && !result_ready) return -1;
    for (int k = 0; k < N; k++) begin
      int i = (m_rr + k) % N;
      if (req_valid[i]) begin
`ifdef VPROC_RESULT_INORDER_EN
        if (m_q.size() > 0 && int'(recs[i].id) == m_q[0]) return i;
`else
        return i;
`endif
      end
    end
    return -1;
  endfunction

  // Called at posedge+1 with inputs already applied; returns to posedge+1 of the next cycle.
  task automatic cycle(output result_t seen, output logic [N-1:0] rdy_seen);
    int w;
    logic [N-1:0] er;
    #3;
    w  = m_pick();
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    rdy_seen = req_ready;
    chk("req_ready", req_ready, er);
    if (w >= 0) begin
      m_out   = recs[w];
      m_valid = 1'b1;
      m_rr    = (w + 1) % N;
`ifdef VPROC_RESULT_INORDER_EN
      void'(m_q.pop_front());
`endif
    end else if (result_ready) begin
      m_valid = 1'b0;
    end
`ifdef VPROC_RESULT_INORDER_EN
    if (commit_valid && !commit_kill) begin
      if (m_q.size() < (1 << IDW)) m_q.push_back(int'(commit_id));
      else m_err = 1'b1;
    end
`endif
    @(posedge clk);
    #1;
    chk("result_valid", result_valid, m_valid);
    if (m_valid) chk("result_o", result, m_out);
    chk("ord_err", ord_err, m_err);
    seen = result;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [N-1:0] vld;
    logic         rdy;
    logic [N-1:0] exp_rdy;
    int           exp_src;
  } vec_t;

  vec_t         tbl [18];
  result_t      seen;
  logic [N-1:0] rs;

  initial begin
    rst_n        = 1'b0;
    req_valid    = '1;
    result_ready = 1'b1;
    commit_valid = 1'b0;
    commit_kill  = 1'b0;
    commit_id    = '0;
    for (int i = 0; i < N; i++) begin
      recs[i]      = result_t'({$urandom, $urandom});
      recs[i].id   = IDW'(i + 1);
    end
    model_reset();
    #1;
    chk("reset_valid", result_valid, 1'b0);
    chk("reset_result", result, '0);
    chk("reset_ready", req_ready, '0);
    chk("reset_ord_err", ord_err, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

`ifndef VPROC_RESULT_INORDER_EN
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 0};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 2};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 3};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 0};
    tbl[5]  = '{4'b0100, 1'b1, 4'b0100, 2};
    for (int r = 6; r <= 10; r++) tbl[r] = '{4'b1111, 1'b0, 4'b0000, 2};
    tbl[11] = '{4'b0000, 1'b1, 4'b0000, -1};
    tbl[12] = '{4'b0011, 1'b1, 4'b0001, 0};
    tbl[13] = '{4'b0011, 1'b1, 4'b0010, 1};
    tbl[14] = '{4'b0000, 1'b0, 4'b0000, 1};
    tbl[15] = '{4'b1111, 1'b0, 4'b0000, 1};
    tbl[16] = '{4'b1111, 1'b1, 4'b0100, 2};
    tbl[17] = '{4'b1111, 1'b1, 4'b1000, 3};
    for (int r = 0; r < 18; r++) begin
      req_valid    = tbl[r].vld;
      result_ready = tbl[r].rdy;
      cycle(seen, rs);
      chk($sformatf("tbl%0d_ready", r), rs, tbl[r].exp_rdy);
      chk($sformatf("tbl%0d_valid", r), result_valid, tbl[r].exp_src >= 0);
      if (tbl[r].exp_src >= 0) chk($sformatf("tbl%0d_rec", r), seen, recs[tbl[r].exp_src]);
    end
`endif

    // Asynchronous reset while a result is held in the stage.
    req_valid    = 4'b0001;
    result_ready = 1'b0;
    cycle(seen, rs);
    cycle(seen, rs);
    req_valid = '1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", result_valid, 1'b0);
    chk("async_rst_result", result, '0);
    chk("async_rst_ready", req_ready, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    result_ready = 1'b1;
    cycle(seen, rs);
`ifdef VPROC_RESULT_INORDER_EN
    chk("post_rst_fifo_empty", rs, 4'b0000);
`else
    chk("post_rst_rr_zero", rs, 4'b0001);
`endif

`ifdef VPROC_RESULT_INORDER_EN
    // Output order follows commit order 5,1,3.
    req_valid  = '0;
    recs[0].id = 3'd3;
    recs[1].id = 3'd1;
    recs[2].id = 3'd5;
    recs[3].id = 3'd7;
    commit_valid = 1'b1;
    commit_id = 3'd5; cycle(seen, rs);
    commit_id = 3'd1; cycle(seen, rs);
    commit_id = 3'd3; cycle(seen, rs);
    commit_valid = 1'b0;
    req_valid    = 4'b0111;
    cycle(seen, rs); chk("order0_id", seen.id, 3'd5);
    cycle(seen, rs); chk("order1_id", seen.id, 3'd1);
    cycle(seen, rs); chk("order2_id", seen.id, 3'd3);
    req_valid = '0;
    cycle(seen, rs);

    // Killed commit is not tracked.
    commit_valid = 1'b1;
    commit_kill  = 1'b1; commit_id = 3'd4; cycle(seen, rs);
    commit_kill  = 1'b0; commit_id = 3'd6; cycle(seen, rs);
    commit_valid = 1'b0;
    recs[3].id   = 3'd6;
    req_valid    = 4'b1000;
    cycle(seen, rs);
    chk("kill_grant", rs, 4'b1000);
    chk("kill_id6", seen.id, 3'd6);
    cycle(seen, rs);
    chk("kill_fifo_empty", rs, 4'b0000);

    // Ninth commit overflows the 8-deep tracker; flag is sticky.
    req_valid = '0;
    do_reset();
    commit_valid = 1'b1;
    for (int c = 0; c < 9; c++) begin
      commit_id = IDW'(c);
      cycle(seen, rs);
      if (c == 7) chk("ovf_not_yet", ord_err, 1'b0);
    end
    chk("ovf_set", ord_err, 1'b1);
    commit_valid = 1'b0;
    cycle(seen, rs);
    cycle(seen, rs);
    chk("ovf_sticky", ord_err, 1'b1);
`endif

    // Randomized run against the model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      req_valid    = N'($urandom);
      result_ready = ($urandom_range(0, 3) != 0);
      commit_valid = ($urandom_range(0, 2) == 0);
      commit_kill  = ($urandom_range(0, 3) == 0);
      commit_id    = IDW'($urandom);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 1) == 1) recs[i] = result_t'({$urandom, $urandom});
      end
      cycle(seen, rs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
